hex_entry_input: RTL

- User-input front end for the board: debounces two active-low pushbuttons and assembles a 16-bit hex value one nibble at a time from four switches.
- Delivers the committed value to the CPU over a valid/ready handshake.
- Exposes the in-progress value so the existing 7-segment path can echo entry live.
- Input-side counterpart of the CPU result-display path.

---
 rtl/hex_entry_input.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hex_entry_input.sv
// Pushbutton-driven hex entry: debounces enter/commit keys, shifts switch nibbles
// into a 16-bit value and hands committed values to the CPU over valid/ready.

module hex_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic Rst,
  input  logic p,
  output logic pulse
);
  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // pulse is decoded from registered state and the synchronized level only
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (p) state_n = ARMING;
      end
      ARMING: begin
        if (!p) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          pulse   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        cnt_n = '0;
        if (!p) state_n = RELEASING;
      end
      RELEASING: begin
        if (p) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

module hex_entry_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [3:0]  sw_nibble,
  input  logic        btn_enter_n,
  input  logic        btn_commit_n,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overrun
);
  localparam int NUM_BTN = 2;  // [0] enter, [1] commit

  logic [NUM_BTN-1:0]      raw_n;
  logic [NUM_BTN-1:0][1:0] sync;
  logic [NUM_BTN-1:0]      pulse;

  assign raw_n = {btn_commit_n, btn_enter_n};

  always_ff @(posedge Clk) begin
    if (Rst) sync <= '1;
    else for (int i = 0; i < NUM_BTN; i++) sync[i] <= {sync[i][0], raw_n[i]};
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    hex_entry_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .Clk  (Clk),
      .Rst  (Rst),
      .p    (~sync[g][1]),
      .pulse(pulse[g])
    );
  end

  logic        enter, commit;
  logic [15:0] val_sh;
  logic [2:0]  cnt_sh;
  logic        commit_ok, commit_rej;

  assign enter  = pulse[0];
  assign commit = pulse[1];

  // commit sees the value after any same-cycle shift
  always_comb begin
    val_sh = entry_value;
    cnt_sh = digit_count;
    if (enter) begin
      val_sh = {entry_value[11:0], sw_nibble};
      cnt_sh = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
    end
  end

  // a slot being consumed this cycle may be refilled in the same cycle
  assign commit_ok  = commit && (cnt_sh != 3'd0) && (!data_valid || data_ready);
  assign commit_rej = commit && (cnt_sh != 3'd0) && data_valid && !data_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      entry_value <= '0;
      digit_count <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else if (commit_ok) begin
      data_out    <= val_sh;
      data_valid  <= 1'b1;
      entry_value <= '0;
      digit_count <= '0;
    end else begin
      entry_value <= val_sh;
      digit_count <= cnt_sh;
      if (commit_rej) overrun <= 1'b1;
      if (data_valid && data_ready) data_valid <= 1'b0;
    end
  end
endmodule
